trdb_d5m_sensor_emulator: RTL and testbench



---
 rtl/trdb_d5m_sensor_emulator.sv | 188 ++++++++++++++++++
 tb/tb_trdb_d5m_sensor_emulator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/trdb_d5m_sensor_emulator.sv
// TRDB-D5M sensor bus emulator: drives FVAL/LVAL/12-bit pixel data with
// programmable frame timing and deterministic test patterns.
module trdb_d5m_sensor_emulator #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_ACTIVE = 480,
  parameter int V_BLANK  = 45,
  parameter int FV_SETUP = 2,
  parameter int CLK_DIV  = 2
) (
  input  logic        ul1Clock,
  input  logic        ul1Reset,
  input  logic        ul1Enable,
  input  logic [1:0]  ulPattern,
  output logic        ul1PixelStrobe,
  output logic        ul1FrameValid,
  output logic        ul1LineValid,
  output logic [11:0] ulPixelData,
  output logic [15:0] ulFrameCount
);

  localparam int FB_TICKS = H_BLANK + V_BLANK * (H_ACTIVE + H_BLANK);
  localparam int CNT_MAX  = FB_TICKS + FV_SETUP;
  localparam int COL_W    = $clog2(H_ACTIVE) + 1;
  localparam int ROW_W    = $clog2(V_ACTIVE) + 1;
  localparam int CNT_W    = $clog2(CNT_MAX + 1) + 1;
  localparam int DIV_W    = $clog2(CLK_DIV) + 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] SETUP_N  = CNT_W'(FV_SETUP);
  localparam logic [CNT_W-1:0] HB_N     = CNT_W'(H_BLANK);
  localparam logic [CNT_W-1:0] FB_N     = CNT_W'(FB_TICKS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACTIVE, S_HBLANK, S_FBLANK
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pat_q, pat_d;
  logic [11:0]      tag_q, tag_d;
  logic [15:0]      fc_q, fc_d;
  logic             fval_q, fval_d;
  logic             lval_q, lval_d;
  logic [11:0]      data_q, data_d;
  logic             tick;
  logic             start;

  function automatic logic [11:0] pixel(input logic [1:0]       pat,
                                        input logic [ROW_W-1:0] row,
                                        input logic [COL_W-1:0] col,
                                        input logic [11:0]      tag);
    logic [11:0] r12;
    logic [11:0] c12;
    r12 = 12'(row);
    c12 = 12'(col);
    case (pat)
      2'd0:    return c12;
      2'd1:    return r12;
      2'd2:    return (r12[0] ^ c12[0]) ? 12'hFFF : 12'h000;
      default: return tag;
    endcase
  endfunction

  // Reset gates the strobe so CLK_DIV=1 still shows 0 while held in reset.
  assign tick = (div_q == DIV_LAST) && !ul1Reset;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    tag_d   = tag_q;
    fc_d    = fc_q;
    fval_d  = fval_q;
    lval_d  = lval_q;
    data_d  = data_q;
    start   = 1'b0;
    div_d   = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          start = ul1Enable;
        end
        S_SETUP: begin
          if (cnt_q < SETUP_N) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = S_ACTIVE;
            col_d   = '0;
          end
        end
        S_ACTIVE: begin
          if (col_q < COL_LAST) begin
            col_d = col_q + COL_W'(1);
          end else if (row_q < ROW_LAST) begin
            if (H_BLANK > 0) begin
              state_d = S_HBLANK;
              cnt_d   = CNT_W'(1);
            end else begin
              row_d = row_q + ROW_W'(1);
              col_d = '0;
            end
          end else begin
            state_d = S_FBLANK;
            cnt_d   = CNT_W'(1);
            fc_d    = fc_q + 16'd1;
          end
        end
        S_HBLANK: begin
          if (cnt_q < HB_N) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            state_d = S_ACTIVE;
            row_d   = row_q + ROW_W'(1);
            col_d   = '0;
          end
        end
        S_FBLANK: begin
          if (cnt_q < FB_N) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (ul1Enable) begin
            start = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Frame start: pattern and tag are frozen here for the whole frame.
      if (start) begin
        pat_d   = ulPattern;
        tag_d   = fc_q[11:0];
        row_d   = '0;
        col_d   = '0;
        cnt_d   = CNT_W'(1);
        state_d = (FV_SETUP > 0) ? S_SETUP : S_ACTIVE;
      end

      fval_d = (state_d == S_SETUP) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
      lval_d = (state_d == S_ACTIVE);
      data_d = lval_d ? pixel(pat_d, row_d, col_d, tag_d) : 12'h000;
    end
  end

  always_ff @(posedge ul1Clock or posedge ul1Reset) begin
    if (ul1Reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      tag_q   <= '0;
      fc_q    <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      tag_q   <= tag_d;
      fc_q    <= fc_d;
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      data_q  <= data_d;
    end
  end

  assign ul1PixelStrobe = tick;
  assign ul1FrameValid  = fval_q;
  assign ul1LineValid   = lval_q;
  assign ulPixelData    = data_q;
  assign ulFrameCount   = fc_q;

endmodule

// File: tb/tb_trdb_d5m_sensor_emulator.sv
// Bench for trdb_d5m_sensor_emulator: three timing variants compared each
// cycle against a frame-position reference model.
module tb_trdb_d5m_sensor_emulator;

  localparam int HA = 4, HB = 2, VA = 3, VB = 2;
  localparam int LINE = HA + HB;
  localparam int ND = 3;
  localparam int FS [ND] = '{1, 1, 0};
  localparam int CD [ND] = '{1, 3, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [1:0] pat = 2'd0;

  logic        stb  [ND];
  logic        fv   [ND];
  logic        lv   [ND];
  logic [11:0] dat  [ND];
  logic [15:0] fcnt [ND];

  always #5 clk = ~clk;

  trdb_d5m_sensor_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                             .FV_SETUP(1), .CLK_DIV(1)) u_dut0 (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Enable(en), .ulPattern(pat),
    .ul1PixelStrobe(stb[0]), .ul1FrameValid(fv[0]), .ul1LineValid(lv[0]),
    .ulPixelData(dat[0]), .ulFrameCount(fcnt[0]));

  trdb_d5m_sensor_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                             .FV_SETUP(1), .CLK_DIV(3)) u_dut1 (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Enable(en), .ulPattern(pat),
    .ul1PixelStrobe(stb[1]), .ul1FrameValid(fv[1]), .ul1LineValid(lv[1]),
    .ulPixelData(dat[1]), .ulFrameCount(fcnt[1]));

  trdb_d5m_sensor_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                             .FV_SETUP(0), .CLK_DIV(2)) u_dut2 (
    .ul1Clock(clk), .ul1Reset(rst), .ul1Enable(en), .ulPattern(pat),
    .ul1PixelStrobe(stb[2]), .ul1FrameValid(fv[2]), .ul1LineValid(lv[2]),
    .ulPixelData(dat[2]), .ulFrameCount(fcnt[2]));

  int n_chk = 0;
  int n_bad = 0;

  // Reference: each frame is a position p in 0..period-1 of one tick sequence.
  int          m_div [ND];
  int          m_p   [ND];
  bit          m_run [ND];
  logic [1:0]  m_pat [ND];
  logic [11:0] m_tag [ND];
  logic [15:0] m_fc  [ND];

  int cyc = 0;
  bit per_on = 1'b0;
  int rise_n [ND];
  int first_cyc [ND];
  logic prev_fv [ND];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%h want=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int period(input int d);
    return FS[d] + (VA + VB) * LINE;
  endfunction

  function automatic logic [11:0] ref_pix(input logic [1:0] p, input int row, input int col,
                                          input logic [11:0] tag);
    case (p)
      2'd0:    return 12'(col);
      2'd1:    return 12'(row);
      2'd2:    return (((row + col) % 2) == 1) ? 12'hFFF : 12'h000;
      default: return tag;
    endcase
  endfunction

  function automatic logic [31:0] model_out(input int d);
    logic s, f, l;
    logic [11:0] px;
    int q;
    s  = !rst && (m_div[d] == CD[d] - 1);
    f  = 1'b0;
    l  = 1'b0;
    px = 12'h000;
    if (m_run[d]) begin
      if (m_p[d] < FS[d]) begin
        f = 1'b1;
      end else begin
        q = m_p[d] - FS[d];
        if (q < VA * LINE - HB) begin
          f = 1'b1;
          if ((q % LINE) < HA) begin
            l  = 1'b1;
            px = ref_pix(m_pat[d], q / LINE, q % LINE, m_tag[d]);
          end
        end
      end
    end
    return {1'b0, s, f, l, px, m_fc[d]};
  endfunction

  task automatic model_edge();
    bit t;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        m_div[d] = 0; m_p[d] = 0; m_run[d] = 1'b0;
        m_pat[d] = 2'd0; m_tag[d] = 12'h000; m_fc[d] = 16'h0000;
      end else begin
        t = (m_div[d] == CD[d] - 1);
        m_div[d] = t ? 0 : m_div[d] + 1;
        if (t) begin
          if (!m_run[d] || m_p[d] == period(d) - 1) begin
            if (en) begin
              m_run[d] = 1'b1; m_p[d] = 0;
              m_pat[d] = pat; m_tag[d] = m_fc[d][11:0];
            end else begin
              m_run[d] = 1'b0;
            end
          end else begin
            m_p[d]++;
          end
          if (m_run[d] && m_p[d] == FS[d] + VA * LINE - HB) m_fc[d]++;
        end
      end
    end
  endtask

  function automatic logic [31:0] dut_out(input int d);
    return {1'b0, stb[d], fv[d], lv[d], dat[d], fcnt[d]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("dut%0d_bus", d), dut_out(d), model_out(d));
      if (per_on && fv[d] && !prev_fv[d]) begin
        if (rise_n[d] == 0) first_cyc[d] = cyc;
        else if (rise_n[d] == 1)
          chk($sformatf("dut%0d_period", d), 32'(cyc - first_cyc[d]), 32'(period(d) * CD[d]));
        rise_n[d]++;
      end
      prev_fv[d] = fv[d];
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos0(input string tag, input int target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_run[0] && m_p[0] == target) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_div[d] = 0; m_p[d] = 0; m_run[d] = 1'b0;
      m_pat[d] = 2'd0; m_tag[d] = 12'h000; m_fc[d] = 16'h0000;
      rise_n[d] = 0; first_cyc[d] = 0; prev_fv[d] = 1'b0;
    end

    // Reset state
    steps(3);
    chk("rst_dut0", dut_out(0), 32'h0);
    chk("rst_dut1", dut_out(1), 32'h0);

    // Continuous frames, horizontal ramp, period measurement
    rst = 1'b0; en = 1'b1; pat = 2'd0; per_on = 1'b1;
    steps(31);
    chk("fc_after_frame1", 32'(fcnt[0]), 32'd1);
    chk("fval_in_fblank", 32'(fv[0]), 32'd0);
    step();
    chk("fval_frame2", 32'(fv[0]), 32'd1);
    steps(200);
    per_on = 1'b0;

    // Checkerboard
    pat = 2'd2;
    steps(120);

    // Drop enable during row 1, frame must complete then idle
    wait_pos0("wait_row1_drop", FS[0] + LINE + 1);
    en = 1'b0;
    steps(300);
    chk("idle_fval", 32'(fv[0]), 32'd0);
    chk("idle_fval_div3", 32'(fv[1]), 32'd0);
    en = 1'b1; pat = 2'd3;
    step();
    chk("restart_fval", 32'(fv[0]), 32'd1);

    // Frame tag for three frames, switch to vertical ramp inside frame 2
    steps(30 + 15);
    pat = 2'd1;
    steps(80);

    // Asynchronous reset during row 1 active
    pat = 2'd0;
    wait_pos0("wait_row1_rst", FS[0] + LINE + 2);
    rst = 1'b1;
    #1;
    chk("async_rst_dut0", dut_out(0), 32'h0);
    chk("async_rst_dut1", dut_out(1), 32'h0);
    chk("async_rst_dut2", dut_out(2), 32'h0);
    steps(2);
    rst = 1'b0;
    step();
    chk("post_rst_fval", 32'(fv[0]), 32'd1);
    step();
    chk("post_rst_first_px", {19'd0, lv[0], dat[0]}, {19'd0, 1'b1, 12'h000});
    steps(60);

    // Randomized enable, pattern and reset activity
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 39) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) pat = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        steps(2);
        rst = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
